// File: rtl/data_cache_ctrl_if.sv
// Line-wide request/ready bus between the data cache controller (master)
// and its backing memory (slave).
interface data_cache_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/data_cache_ctrl.sv
// Write-back, write-allocate, direct-mapped data cache controller with
// byte/half/word access, multi-cycle line refill/writeback and a whole-cache flush.
module data_cache_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int NUM_SETS       = 64,
  parameter int LINE_WIDTH     = DATA_WIDTH*WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  stall,
  output logic                  misaligned,
  input  logic                  flush,
  output logic                  flush_done,
  data_cache_ctrl_if.master     mem
);
  localparam int OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int IDX_W   = $clog2(NUM_SETS);
  localparam int TAG_LSB = 2 + OFF_W + IDX_W;
  localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;

  typedef enum logic [2:0] {IDLE, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      set_cnt_q, set_cnt_d;
  logic [NUM_SETS-1:0]   valid_q, valid_d, dirty_q, dirty_d;
  logic                  flush_done_q, flush_done_d;
  logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic [TAG_W-1:0]      tag_q  [NUM_SETS];
  logic [LINE_WIDTH-1:0] line_q [NUM_SETS];

  logic                  arr_we, arr_tag_we;
  logic [IDX_W-1:0]      arr_idx;
  logic [TAG_W-1:0]      arr_tag;
  logic [LINE_WIDTH-1:0] arr_line;

  logic [1:0]            byte_off;
  logic [OFF_W-1:0]      word_sel;
  logic [IDX_W-1:0]      index;
  logic [TAG_W-1:0]      tag;
  logic                  req, access_ok, hit, victim_dirty, is_byte, is_half, is_signed;
  logic [LINE_WIDTH-1:0] cur_line, merged_line;
  logic [DATA_WIDTH-1:0] cur_word, shifted, load_val, st_data, merged_word;
  logic [3:0]            st_mask;
  logic                  last_set;

  assign byte_off = addr[1:0];
  assign word_sel = addr[2 +: OFF_W];
  assign index    = addr[2+OFF_W +: IDX_W];
  assign tag      = addr[TAG_LSB +: TAG_W];
  assign req      = rd_en | wr_en;

  // Store codes other than B/H fall back to W; loads also accept BU/HU.
  assign is_byte   = wr_en ? (funct3 == 3'b000) : (funct3 == 3'b000 || funct3 == 3'b100);
  assign is_half   = wr_en ? (funct3 == 3'b001) : (funct3 == 3'b001 || funct3 == 3'b101);
  assign is_signed = ~funct3[2];

  assign misaligned = ~rst & req & ((is_half & addr[0]) |
                                    (~is_byte & ~is_half & (addr[1:0] != 2'b00)));
  assign access_ok    = req & ~misaligned;
  assign cur_line     = line_q[index];
  assign hit          = valid_q[index] && (tag_q[index] == tag);
  assign victim_dirty = valid_q[index] & dirty_q[index];
  assign last_set     = (set_cnt_q == IDX_W'(NUM_SETS-1));

  always_comb begin
    cur_word = '0;
    for (int w = 0; w < WORDS_PER_LINE; w++)
      if (word_sel == OFF_W'(w)) cur_word = cur_line[w*DATA_WIDTH +: DATA_WIDTH];

    shifted = cur_word >> {byte_off, 3'b000};
    if (is_byte)      load_val = {{(DATA_WIDTH-8){is_signed & shifted[7]}}, shifted[7:0]};
    else if (is_half) load_val = {{(DATA_WIDTH-16){is_signed & shifted[15]}}, shifted[15:0]};
    else              load_val = cur_word;

    if (is_byte) begin
      st_data = {4{wr_data[7:0]}};
      st_mask = 4'b0001 << byte_off;
    end else if (is_half) begin
      st_data = {2{wr_data[15:0]}};
      st_mask = 4'b0011 << byte_off;
    end else begin
      st_data = wr_data;
      st_mask = 4'b1111;
    end

    for (int b = 0; b < 4; b++)
      merged_word[b*8 +: 8] = st_mask[b] ? st_data[b*8 +: 8] : cur_word[b*8 +: 8];

    merged_line = cur_line;
    for (int w = 0; w < WORDS_PER_LINE; w++)
      if (word_sel == OFF_W'(w)) merged_line[w*DATA_WIDTH +: DATA_WIDTH] = merged_word;
  end

  always_comb begin
    state_d      = state_q;
    set_cnt_d    = set_cnt_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    flush_done_d = 1'b0;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    arr_we       = 1'b0;
    arr_tag_we   = 1'b0;
    arr_idx      = index;
    arr_tag      = tag;
    arr_line     = merged_line;
    stall        = 1'b1;
    rd_data      = '0;

    case (state_q)
      IDLE: begin
        stall = 1'b0;
        if (flush) begin
          state_d   = FLUSH_SCAN;
          set_cnt_d = '0;
          stall     = access_ok;
        end else if (access_ok) begin
          if (hit) begin
            if (rd_en) rd_data = load_val;
            if (wr_en) begin
              arr_we         = 1'b1;
              dirty_d[index] = 1'b1;
            end
          end else begin
            stall     = 1'b1;
            mem_req_d = 1'b1;
            if (victim_dirty) begin
              state_d     = WRITEBACK;
              mem_we_d    = 1'b1;
              mem_addr_d  = {tag_q[index], index, {(OFF_W+2){1'b0}}};
              mem_wdata_d = cur_line;
            end else begin
              state_d    = REFILL;
              mem_we_d   = 1'b0;
              mem_addr_d = {tag, index, {(OFF_W+2){1'b0}}};
            end
          end
        end
      end
      WRITEBACK: if (mem.mem_ready) begin
        state_d    = REFILL;
        mem_we_d   = 1'b0;
        mem_addr_d = {tag, index, {(OFF_W+2){1'b0}}};
      end
      REFILL: if (mem.mem_ready) begin
        // Install at the registered refill address so the line lands where it was fetched from.
        arr_we     = 1'b1;
        arr_tag_we = 1'b1;
        arr_idx    = mem_addr_q[2+OFF_W +: IDX_W];
        arr_tag    = mem_addr_q[TAG_LSB +: TAG_W];
        arr_line   = mem.mem_rdata;
        valid_d[mem_addr_q[2+OFF_W +: IDX_W]] = 1'b1;
        dirty_d[mem_addr_q[2+OFF_W +: IDX_W]] = 1'b0;
        mem_req_d  = 1'b0;
        state_d    = IDLE;
      end
      FLUSH_SCAN: begin
        if (valid_q[set_cnt_q] && dirty_q[set_cnt_q]) begin
          state_d     = FLUSH_WB;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {tag_q[set_cnt_q], set_cnt_q, {(OFF_W+2){1'b0}}};
          mem_wdata_d = line_q[set_cnt_q];
        end else if (last_set) begin
          flush_done_d = 1'b1;
          set_cnt_d    = '0;
          state_d      = IDLE;
        end else begin
          set_cnt_d = set_cnt_q + IDX_W'(1);
        end
      end
      FLUSH_WB: if (mem.mem_ready) begin
        dirty_d[set_cnt_q] = 1'b0;
        mem_req_d          = 1'b0;
        mem_we_d           = 1'b0;
        set_cnt_d          = last_set ? '0 : set_cnt_q + IDX_W'(1);
        state_d            = last_set ? IDLE : FLUSH_SCAN;
        flush_done_d       = last_set;
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      stall   = 1'b0;
      rd_data = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      set_cnt_q    <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      flush_done_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      set_cnt_q    <= set_cnt_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      flush_done_q <= flush_done_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (arr_we)     line_q[arr_idx] <= arr_line;
    if (arr_tag_we) tag_q[arr_idx]  <= arr_tag;
  end

  assign flush_done    = flush_done_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench for data_cache_ctrl: behavioural backing memory with
// programmable latency, transaction log and hand-computed expectations.
module tb_data_cache_ctrl;
  logic        clk;
  logic        rst;
  logic        rd_en, wr_en, flush;
  logic [31:0] addr, wr_data;
  logic [2:0]  funct3;
  logic [31:0] rd_data;
  logic        stall, misaligned, flush_done;

  data_cache_ctrl_if #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) mif ();

  data_cache_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .WORDS_PER_LINE(4), .NUM_SETS(64)
  ) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .wr_data(wr_data), .funct3(funct3), .rd_data(rd_data), .stall(stall),
    .misaligned(misaligned), .flush(flush), .flush_done(flush_done), .mem(mif.master)
  );

  int checks = 0;
  int errors = 0;
  int mem_lat = 0;
  int wait_cnt = 0;

  logic [127:0] mem_model [logic [31:0]];
  logic [31:0]  log_addr [$];
  logic         log_we [$];
  logic [127:0] log_wdata [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Untouched lines read back with each word equal to its own byte address.
  function automatic logic [127:0] readLine(input logic [31:0] a);
    logic [127:0] l;
    if (mem_model.exists(a)) return mem_model[a];
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = a + 32'(w*4);
    return l;
  endfunction

  initial begin
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || !mif.mem_req || mif.mem_ready) begin
        mif.mem_ready = 1'b0;
        wait_cnt = 0;
      end else if (wait_cnt >= mem_lat) begin
        mif.mem_ready = 1'b1;
        log_addr.push_back(mif.mem_addr);
        log_we.push_back(mif.mem_we);
        log_wdata.push_back(mif.mem_wdata);
        if (mif.mem_we) mem_model[mif.mem_addr] = mif.mem_wdata;
        else            mif.mem_rdata = readLine(mif.mem_addr);
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [2:0] f3, input logic fl);
    @(negedge clk);
    rd_en = rd; wr_en = wr; addr = a; wr_data = d; funct3 = f3; flush = fl;
    #1;
  endtask

  task automatic holdCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic waitNoStall(input string tag, input int max_cycles);
    int n = 0;
    while (stall && n < max_cycles) begin
      holdCycle();
      n++;
    end
    checkOutput(tag, stall, 1'b0);
  endtask

  int n0, cyc, early_idle, done_seen;

  initial begin
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; flush = 1'b0;
    addr = '0; wr_data = '0; funct3 = 3'b010;
    mem_model[32'h100] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_stall", stall, 1'b0);
    checkOutput("rst_mem_req", mif.mem_req, 1'b0);
    checkOutput("rst_mem_we", mif.mem_we, 1'b0);
    checkOutput("rst_mem_addr", mif.mem_addr, 32'h0);
    checkOutput("rst_rd_data", rd_data, 32'h0);
    checkOutput("rst_flush_done", flush_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Cold load miss with a slow memory.
    mem_lat = 3;
    applyStimulus(1, 0, 32'h100, 0, 3'b010, 0);
    checkOutput("cold_stall", stall, 1'b1);
    checkOutput("cold_req_not_yet", mif.mem_req, 1'b0);
    holdCycle();
    checkOutput("cold_req", mif.mem_req, 1'b1);
    checkOutput("cold_we", mif.mem_we, 1'b0);
    checkOutput("cold_addr", mif.mem_addr, 32'h100);
    waitNoStall("cold_unstall", 20);
    checkOutput("cold_rd", rd_data, 32'h11111111);

    // Sub-word stores and loads on the resident line.
    n0 = log_addr.size();
    applyStimulus(0, 1, 32'h103, 32'h000000AB, 3'b000, 0);
    checkOutput("sb_stall", stall, 1'b0);
    applyStimulus(1, 0, 32'h103, 0, 3'b100, 0);
    checkOutput("lbu", rd_data, 32'h000000AB);
    applyStimulus(1, 0, 32'h103, 0, 3'b000, 0);
    checkOutput("lb", rd_data, 32'hFFFFFFAB);
    applyStimulus(1, 0, 32'h100, 0, 3'b010, 0);
    checkOutput("lw_merged", rd_data, 32'hAB111111);
    applyStimulus(1, 0, 32'h102, 0, 3'b101, 0);
    checkOutput("lhu", rd_data, 32'h0000AB11);
    applyStimulus(1, 0, 32'h102, 0, 3'b001, 0);
    checkOutput("lh", rd_data, 32'hFFFFAB11);
    applyStimulus(1, 0, 32'h104, 0, 3'b010, 0);
    checkOutput("lw_word1", rd_data, 32'h22222222);
    applyStimulus(1, 1, 32'h108, 32'hCAFEBABE, 3'b010, 0);
    checkOutput("rdwr_pre_store", rd_data, 32'h33333333);
    applyStimulus(1, 0, 32'h108, 0, 3'b010, 0);
    checkOutput("lw_after_sw", rd_data, 32'hCAFEBABE);

    // Misaligned accesses.
    applyStimulus(1, 0, 32'h102, 0, 3'b010, 0);
    checkOutput("mis_lw_flag", misaligned, 1'b1);
    checkOutput("mis_lw_stall", stall, 1'b0);
    checkOutput("mis_lw_rd", rd_data, 32'h0);
    applyStimulus(1, 0, 32'h101, 0, 3'b001, 0);
    checkOutput("mis_lh_flag", misaligned, 1'b1);
    checkOutput("mis_lh_req", mif.mem_req, 1'b0);
    applyStimulus(0, 1, 32'h101, 32'h55, 3'b001, 0);
    checkOutput("mis_sh_flag", misaligned, 1'b1);
    applyStimulus(1, 0, 32'h100, 0, 3'b010, 0);
    checkOutput("mis_unchanged", rd_data, 32'hAB111111);
    checkOutput("aligned_flag", misaligned, 1'b0);
    checkOutput("hit_no_traffic", log_addr.size(), n0);

    // Conflict miss on a dirty victim.
    mem_lat = 1;
    applyStimulus(1, 0, 32'h500, 0, 3'b010, 0);
    checkOutput("wb_stall", stall, 1'b1);
    holdCycle();
    checkOutput("wb_req", mif.mem_req, 1'b1);
    checkOutput("wb_we", mif.mem_we, 1'b1);
    checkOutput("wb_addr", mif.mem_addr, 32'h100);
    checkOutput("wb_word0", mif.mem_wdata[31:0], 32'hAB111111);
    checkOutput("wb_word2", mif.mem_wdata[95:64], 32'hCAFEBABE);
    cyc = 0;
    while (mif.mem_we && cyc < 20) begin holdCycle(); cyc++; end
    checkOutput("refill_req", mif.mem_req, 1'b1);
    checkOutput("refill_we", mif.mem_we, 1'b0);
    checkOutput("refill_addr", mif.mem_addr, 32'h500);
    waitNoStall("conflict_unstall", 20);
    checkOutput("conflict_rd", rd_data, 32'h500);

    // Dirty lines in sets 3 and 9, then flush.
    mem_lat = 0;
    applyStimulus(1, 0, 32'h30, 0, 3'b010, 0);
    waitNoStall("set3_fill", 20);
    checkOutput("set3_rd", rd_data, 32'h30);
    applyStimulus(0, 1, 32'h30, 32'h12345678, 3'b010, 0);
    applyStimulus(1, 0, 32'h94, 0, 3'b010, 0);
    waitNoStall("set9_fill", 20);
    checkOutput("set9_rd", rd_data, 32'h94);
    applyStimulus(0, 1, 32'h94, 32'h9ABCDEF0, 3'b010, 0);
    applyStimulus(0, 0, 0, 0, 3'b010, 0);
    n0 = log_addr.size();
    applyStimulus(0, 0, 0, 0, 3'b010, 1);
    applyStimulus(0, 0, 0, 0, 3'b010, 0);
    cyc = 0;
    while (!flush_done && cyc < 400) begin holdCycle(); cyc++; end
    checkOutput("flush_done_seen", flush_done, 1'b1);
    holdCycle();
    checkOutput("flush_done_pulse", flush_done, 1'b0);
    checkOutput("flush_wb_count", log_addr.size(), n0 + 2);
    if (log_addr.size() >= n0 + 2) begin
      checkOutput("flush_wb0_addr", log_addr[n0], 32'h30);
      checkOutput("flush_wb0_we", log_we[n0], 1'b1);
      checkOutput("flush_wb0_data", log_wdata[n0][31:0], 32'h12345678);
      checkOutput("flush_wb1_addr", log_addr[n0+1], 32'h90);
      checkOutput("flush_wb1_data", log_wdata[n0+1][63:32], 32'h9ABCDEF0);
    end
    n0 = log_addr.size();
    applyStimulus(1, 0, 32'h30, 0, 3'b010, 0);
    checkOutput("post_flush_hit3", stall, 1'b0);
    checkOutput("post_flush_rd3", rd_data, 32'h12345678);
    applyStimulus(1, 0, 32'h94, 0, 3'b010, 0);
    checkOutput("post_flush_hit9", stall, 1'b0);
    checkOutput("post_flush_rd9", rd_data, 32'h9ABCDEF0);

    // Clean flush with a simultaneous load: priority and NUM_SETS+1 latency.
    applyStimulus(1, 0, 32'h30, 0, 3'b010, 1);
    checkOutput("flush_prio_stall", stall, 1'b1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    cyc = 1;
    early_idle = 0;
    done_seen = 0;
    while (!flush_done && cyc < 400) begin
      if (!stall) early_idle++;
      holdCycle();
      cyc++;
    end
    checkOutput("clean_flush_cycles", cyc, 65);
    checkOutput("clean_flush_stalled", early_idle, 0);
    checkOutput("clean_flush_hit", stall, 1'b0);
    checkOutput("clean_flush_rd", rd_data, 32'h12345678);
    checkOutput("flush_no_traffic", log_addr.size(), n0);

    // Reset in the middle of a refill.
    mem_lat = 10000;
    applyStimulus(1, 0, 32'h700, 0, 3'b010, 0);
    holdCycle();
    checkOutput("abort_req_up", mif.mem_req, 1'b1);
    checkOutput("abort_addr", mif.mem_addr, 32'h700);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_req_drop", mif.mem_req, 1'b0);
    checkOutput("abort_stall_drop", stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mem_lat = 2;
    applyStimulus(1, 0, 32'h100, 0, 3'b010, 0);
    checkOutput("after_rst_miss", stall, 1'b1);
    waitNoStall("after_rst_unstall", 20);
    checkOutput("after_rst_rd", rd_data, 32'hAB111111);
    applyStimulus(1, 0, 32'h30, 0, 3'b010, 0);
    checkOutput("after_rst_miss3", stall, 1'b1);
    waitNoStall("after_rst_unstall3", 20);
    checkOutput("after_rst_rd3", rd_data, 32'h12345678);

    applyStimulus(0, 0, 0, 0, 3'b010, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/data_cache_ctrl.md
Name: data_cache_ctrl

Overview:
Parametrised write-back, write-allocate, direct-mapped data cache controller between the execute/memory stage and a block-wide backing data memory. It replaces the fixed 4-word, single-cycle cache/memory pairing. It adds:
- configurable line size and set count
- a multi-cycle req/ready memory handshake with a CPU stall
- byte/half/word loads and stores with sign extension and a misaligned-access flag
- a whole-cache flush sequence

Parameters:
DATA_WIDTH, 32, CPU word width in bits (fixed at 32 for funct3 decoding)
ADDR_WIDTH, 32, byte address width
WORDS_PER_LINE, 4, words per cache line (power of 2, ≥2)
NUM_SETS, 64, number of lines (power of 2)
LINE_WIDTH, DATA_WIDTH*WORDS_PER_LINE, derived line width in bits

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
rd_en  in  1  load request
wr_en  in  1  store request
addr  in  ADDR_WIDTH  byte address (ALU result)
wr_data  in  DATA_WIDTH  store data, right-aligned
funct3  in  3  access size/sign
rd_data  out  DATA_WIDTH  extended load result
stall  out  1  CPU must hold request and freeze the pipeline
misaligned  out  1  access not naturally aligned
flush  in  1  single-cycle pulse: write back all dirty lines
flush_done  out  1  one-cycle pulse when flush completes
mem_req  out  1  backing memory request
mem_we  out  1  1 = line write, 0 = line read
mem_addr  out  ADDR_WIDTH  line-aligned address (offset bits zero)
mem_wdata  out  LINE_WIDTH  line being written back
mem_rdata  in  LINE_WIDTH  line returned by memory
mem_ready  in  1  transfer completes on the edge where mem_req&&mem_ready

Behaviour:
- Address split:
  - byte offset [1:0]
  - word select next log2(WORDS_PER_LINE) bits
  - index next log2(NUM_SETS) bits
  - tag = remaining upper bits
- Per-set state: valid, dirty, tag, line.
- Reset, asynchronous:
  - all valid/dirty bits cleared; state = IDLE; set counter = 0
  - rd_data, stall, misaligned, flush_done, mem_req, mem_we = 0; mem_addr, mem_wdata = 0
  - line/tag contents are don't-care
- Reset during WRITEBACK/REFILL aborts the transfer; mem_req drops immediately; dirty data is lost.
- Access (req = rd_en|wr_en):
  - Misaligned:
    - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, gives misaligned=1 combinationally.
    - No cache update, no stall, no mem_req, rd_data = 0.
  - funct3 decode:
    - 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
    - Store uses 000/001/010 only.
    - Any other code is treated as W.
  - Hit (IDLE, valid && tag match):
    - rd_data is combinational from the line, byte/half selected by addr[1:0], zero/sign extended.
    - Stores merge bytes into the line at the edge and set dirty.
    - stall = 0; latency 0.
  - wr_en and rd_en both high: treated as a store; rd_data shows pre-store data.
  - Miss: stall = 1 combinationally in the same cycle.
    - Victim valid && dirty: go to WRITEBACK.
    - Otherwise: go to REFILL.
- FSM states: IDLE, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB.
  - WRITEBACK:
    - mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wdata = victim line.
    - On mem_ready go to REFILL.
  - REFILL:
    - mem_req=1, mem_we=0, mem_addr = requested line base.
    - On mem_ready: line <= mem_rdata, tag written, valid=1, dirty=0; go to IDLE.
    - The held request then hits (stall=0 that cycle).
  - mem_req/mem_we/mem_addr/mem_wdata are registered and stable from assertion until the completing edge.
  - mem_ready while mem_req=0 is ignored.
  - stall=1 in every non-IDLE state.
- Flush:
  - Accepted only in IDLE; it takes priority over a simultaneous access, which then stalls.
  - flush in any other state is ignored.
  - FLUSH_SCAN walks sets 0..NUM_SETS-1, one per cycle.
  - A valid && dirty set goes to FLUSH_WB: write back, clear dirty (line stays valid), resume at the next set.
  - After the last set: flush_done = 1 for one cycle, return to IDLE.
  - Set counter wraps to 0.
  - Flush with no dirty lines takes NUM_SETS+1 cycles.

Test Plan:
- Cold LW addr 0x100: stall=1, then mem_req=1, mem_we=0, mem_addr=0x100. Return mem_rdata words {0x44444444,0x33333333,0x22222222,0x11111111} with mem_ready after 3 cycles -> next cycle stall=0, rd_data=0x11111111.
- After line 0x100 is resident, SB addr 0x103 wr_data 0xAB -> LBU 0x103 = 0x000000AB, LB 0x103 = 0xFFFFFFAB, LW 0x100 = 0xAB111111. No memory traffic.
- Dirty line 0x100 resident, LW 0x500 (same index 16):
  - WRITEBACK first: mem_we=1, mem_addr=0x100, mem_wdata holding 0xAB111111 in word0.
  - Then REFILL mem_addr=0x500.
  - Then hit.
- LW 0x102 and LH 0x101 -> misaligned=1, stall=0, mem_req stays 0, cache unchanged.
- Dirty lines in sets 3 and 9, flush pulse:
  - exactly two writebacks, in order set 3 then set 9, mem_ready immediate
  - flush_done pulses once after set 63
  - re-reading both lines hits with no traffic
- rst asserted mid-REFILL with mem_ready low -> mem_req=0 and stall=0 immediately; subsequent LW 0x100 misses again.
